// File: rtl/sfx_voice_mixer.sv
// Polyphonic button sound generator: each button edge starts a decaying square-wave voice;
// voices are allocated or stolen, mixed, optionally panned, and saturated to the audio width.
module sfx_voice_mixer #(
  parameter int unsigned NUM_BTN    = 8,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned CLK_DIV    = 1024,
  parameter int unsigned BASE_HALF  = 40,
  parameter int unsigned STEP_HALF  = 8,
  parameter int unsigned AMP_INIT   = 8000,
  parameter int unsigned DECAY      = 1,
  parameter int unsigned AUDIO_W    = 16
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [NUM_BTN-1:0]        btn,
  input  logic                      low_batt,
  input  logic                      pan_en,
  output logic                      sample_tick,
  output logic [NUM_VOICES-1:0]     voices_active,
  output logic signed [AUDIO_W-1:0] audio_l,
  output logic signed [AUDIO_W-1:0] audio_r
);

  localparam int unsigned BTN_W    = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int unsigned VOICE_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned AMP_W    = AUDIO_W;
  localparam int unsigned MAX_HALF = 2 * (BASE_HALF + (NUM_BTN - 1) * STEP_HALF);
  localparam int unsigned PH_W     = $clog2(MAX_HALF + 1);
  localparam int unsigned ACC_W    = AUDIO_W + $clog2(NUM_VOICES) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (AUDIO_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [NUM_BTN-1:0]  sync1;
  logic [NUM_BTN-1:0]  sync2;
  logic [NUM_BTN-1:0]  prev;
  logic [NUM_BTN-1:0]  pending;
  logic [NUM_BTN-1:0]  rise_c;
  logic [NUM_BTN-1:0]  clr_c;
  logic [NUM_BTN-1:0]  pending_n;

  logic                svc_valid_c;
  logic [BTN_W-1:0]    svc_btn_c;
  logic [VOICE_W-1:0]  alloc_voice_c;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick_c;

  logic [AMP_W-1:0]    amp     [NUM_VOICES];
  logic [AMP_W-1:0]    amp_n   [NUM_VOICES];
  logic [PH_W-1:0]     phase   [NUM_VOICES];
  logic [PH_W-1:0]     phase_n [NUM_VOICES];
  logic                pol     [NUM_VOICES];
  logic                pol_n   [NUM_VOICES];
  logic [BTN_W-1:0]    owner   [NUM_VOICES];
  logic [BTN_W-1:0]    owner_n [NUM_VOICES];
  logic [PH_W-1:0]     half_c  [NUM_VOICES];

  logic signed [ACC_W-1:0] acc_l_c;
  logic signed [ACC_W-1:0] acc_r_c;

  function automatic logic signed [AUDIO_W-1:0] saturate(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) return AUDIO_W'(SAT_MAX);
    if (x < SAT_MIN) return AUDIO_W'(SAT_MIN);
    return AUDIO_W'(x);
  endfunction

  // Synchroniser, edge detect and pending-request register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      pending <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= pending_n;
    end
  end

  assign rise_c    = sync2 & ~prev;
  assign clr_c     = svc_valid_c ? (NUM_BTN'(1) << svc_btn_c) : '0;
  assign pending_n = (pending & ~clr_c) | rise_c;

  // Allocator: lowest pending button; owner retrigger, else lowest free, else quietest voice
  always_comb begin
    logic               found_own;
    logic               found_free;
    logic [VOICE_W-1:0] own_v;
    logic [VOICE_W-1:0] free_v;
    logic [VOICE_W-1:0] steal_v;
    logic [AMP_W-1:0]   min_amp;

    svc_valid_c = 1'b0;
    svc_btn_c   = '0;
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        svc_valid_c = 1'b1;
        svc_btn_c   = BTN_W'(i);
      end
    end

    found_own  = 1'b0;
    found_free = 1'b0;
    own_v      = '0;
    free_v     = '0;
    steal_v    = '0;
    min_amp    = '1;
    for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
      if (amp[v] != '0 && owner[v] == svc_btn_c) begin
        found_own = 1'b1;
        own_v     = VOICE_W'(v);
      end
      if (amp[v] == '0) begin
        found_free = 1'b1;
        free_v     = VOICE_W'(v);
      end
      if (amp[v] <= min_amp) begin
        min_amp = amp[v];
        steal_v = VOICE_W'(v);
      end
    end

    if (found_own)       alloc_voice_c = own_v;
    else if (found_free) alloc_voice_c = free_v;
    else                 alloc_voice_c = steal_v;
  end

  // Sample-rate divider
  assign tick_c = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
  end

  // Half-period per voice, doubled in low-battery mode for the octave drop
  always_comb begin
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      half_c[v] = PH_W'(BASE_HALF) + PH_W'(owner[v]) * PH_W'(STEP_HALF);
      if (low_batt) half_c[v] = half_c[v] << 1;
    end
  end

  // Voice next state: a load always overrides that tick's advance and decay
  always_comb begin
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      amp_n[v]   = amp[v];
      phase_n[v] = phase[v];
      pol_n[v]   = pol[v];
      owner_n[v] = owner[v];
      if (svc_valid_c && alloc_voice_c == VOICE_W'(v)) begin
        amp_n[v]   = AMP_W'(AMP_INIT);
        phase_n[v] = '0;
        pol_n[v]   = 1'b1;
        owner_n[v] = svc_btn_c;
      end else if (tick_c && amp[v] != '0) begin
        if (phase[v] == half_c[v] - PH_W'(1)) begin
          phase_n[v] = '0;
          pol_n[v]   = ~pol[v];
        end else begin
          phase_n[v] = phase[v] + PH_W'(1);
        end
        amp_n[v] = (amp[v] > AMP_W'(DECAY)) ? amp[v] - AMP_W'(DECAY) : '0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        amp[v]   <= '0;
        phase[v] <= '0;
        pol[v]   <= 1'b1;
        owner[v] <= '0;
      end
      voices_active <= '0;
    end else begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        amp[v]           <= amp_n[v];
        phase[v]         <= phase_n[v];
        pol[v]           <= pol_n[v];
        owner[v]         <= owner_n[v];
        voices_active[v] <= (amp_n[v] != '0);
      end
    end
  end

  // Mixer: signed voice samples, optional half-level cross-feed for panning
  always_comb begin
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] s_half;
    acc_l_c = '0;
    acc_r_c = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      s = ACC_W'(amp[v]);
      if (!pol[v]) s = -s;
      if (low_batt) s = s >>> 1;
      s_half = s >>> 1;
      if (!pan_en) begin
        acc_l_c = acc_l_c + s;
        acc_r_c = acc_r_c + s;
      end else if ((v % 2) == 0) begin
        acc_l_c = acc_l_c + s;
        acc_r_c = acc_r_c + s_half;
      end else begin
        acc_l_c = acc_l_c + s_half;
        acc_r_c = acc_r_c + s;
      end
    end
  end

  // Output registers; audio samples the pre-update voice state on the tick cycle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sample_tick <= 1'b0;
      audio_l     <= '0;
      audio_r     <= '0;
    end else begin
      sample_tick <= tick_c;
      if (tick_c) begin
        audio_l <= saturate(acc_l_c);
        audio_r <= saturate(acc_r_c);
      end
    end
  end

endmodule

// File: tb/tb_sfx_voice_mixer.sv
// Self-checking bench for sfx_voice_mixer: table-driven single-press vectors plus hand-written
// sequences for stealing, retrigger, reset-hold, saturation and reset mid-play.
`timescale 1ns/1ps
module tb_sfx_voice_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [7:0]        btn;
  logic              low_batt;
  logic              pan_en;
  logic              sample_tick;
  logic [1:0]        voices_active;
  logic signed [15:0] audio_l;
  logic signed [15:0] audio_r;

  logic              reset_b;
  logic [7:0]        btn_b;
  logic              low_batt_b;
  logic              pan_en_b;
  logic              sample_tick_b;
  logic [3:0]        voices_active_b;
  logic signed [15:0] audio_l_b;
  logic signed [15:0] audio_r_b;

  sfx_voice_mixer #(
    .NUM_BTN(8), .NUM_VOICES(2), .CLK_DIV(4), .BASE_HALF(2), .STEP_HALF(1),
    .AMP_INIT(100), .DECAY(10), .AUDIO_W(16)
  ) dut (
    .clk_sys(clk), .reset(reset), .btn(btn), .low_batt(low_batt), .pan_en(pan_en),
    .sample_tick(sample_tick), .voices_active(voices_active),
    .audio_l(audio_l), .audio_r(audio_r)
  );

  sfx_voice_mixer #(
    .NUM_BTN(8), .NUM_VOICES(4), .CLK_DIV(4), .BASE_HALF(2), .STEP_HALF(1),
    .AMP_INIT(30000), .DECAY(10), .AUDIO_W(16)
  ) dut_b (
    .clk_sys(clk), .reset(reset_b), .btn(btn_b), .low_batt(low_batt_b), .pan_en(pan_en_b),
    .sample_tick(sample_tick_b), .voices_active(voices_active_b),
    .audio_l(audio_l_b), .audio_r(audio_r_b)
  );

  typedef struct { int l; int r; } samp_t;
  typedef struct {
    logic [7:0] btn;
    logic       lb;
    logic       pe;
    int         va;
    int         l [12];
    int         r [12];
  } vec_t;

  samp_t q_a[$];
  samp_t q_b[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: one expected sample per sample tick while entries are queued
  always @(negedge clk) begin
    samp_t e;
    if (sample_tick && q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_audio_l", int'(audio_l), e.l);
      check("a_audio_r", int'(audio_r), e.r);
    end
  end

  always @(negedge clk) begin
    samp_t e;
    if (sample_tick_b && q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_audio_l", int'(audio_l_b), e.l);
      check("b_audio_r", int'(audio_r_b), e.r);
    end
  end

  task automatic wait_tick(input int which);
    int got;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ((which == 0 && sample_tick) || (which == 1 && sample_tick_b)) begin
        got = 1;
        break;
      end
    end
    check("tick_seen", got, 1);
  endtask

  task automatic push_a(input int l, input int r);
    samp_t s;
    s.l = l;
    s.r = r;
    q_a.push_back(s);
  endtask

  task automatic drain(input int which);
    for (int c = 0; c < 400; c++) begin
      if ((which == 0 ? q_a.size() : q_b.size()) == 0) break;
      @(negedge clk);
    end
    check("drain", (which == 0 ? q_a.size() : q_b.size()), 0);
  endtask

  task automatic pulse_a(input logic [7:0] mask);
    btn = mask;
    @(negedge clk);
    #1 btn = '0;
  endtask

  task automatic reset_a(input logic lb, input logic pe);
    reset    = 1'b1;
    btn      = '0;
    low_batt = lb;
    pan_en   = pe;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  vec_t vecs [4];
  int   steal_exp [18];
  int   retrig_exp [19];
  int   sat_exp [9];

  initial begin
    vecs[0].btn = 8'h01; vecs[0].lb = 1'b0; vecs[0].pe = 1'b0; vecs[0].va = 1;
    vecs[0].l = '{0, 100, 90, -80, -70, 60, 50, -40, -30, 20, 10, 0};
    vecs[0].r = vecs[0].l;
    vecs[1].btn = 8'h01; vecs[1].lb = 1'b1; vecs[1].pe = 1'b0; vecs[1].va = 1;
    vecs[1].l = '{0, 50, 45, 40, 35, -30, -25, -20, -15, 10, 5, 0};
    vecs[1].r = vecs[1].l;
    vecs[2].btn = 8'h03; vecs[2].lb = 1'b0; vecs[2].pe = 1'b1; vecs[2].va = 3;
    vecs[2].l = '{0, 150, 135, -40, -105, 30, 25, -20, -15, 30, 5, 0};
    vecs[2].r = '{0, 150, 135, 40, -105, -30, -25, 20, 15, 30, -5, 0};
    vecs[3].btn = 8'h02; vecs[3].lb = 1'b0; vecs[3].pe = 1'b0; vecs[3].va = 1;
    vecs[3].l = '{0, 100, 90, 80, -70, -60, -50, 40, 30, 20, -10, 0};
    vecs[3].r = vecs[3].l;
    steal_exp  = '{0, 100, 90, -80, 30, 150, 130, 30, 30, 30, 110, -30, -30, -50, -30, 20, 10, 0};
    retrig_exp = '{0, 100, 90, -80, -70, 60, 50, -40, 100, 90, -80, -70, 60, 50, -40, -30, 20, 10, 0};
    sat_exp    = '{0, 32767, 32767, 32767, 0, 0, -32768, -32768, -32768};

    reset = 1'b1; btn = '0; low_batt = 1'b0; pan_en = 1'b0;
    reset_b = 1'b1; btn_b = '0; low_batt_b = 1'b0; pan_en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tick", int'(sample_tick), 0);
    check("rst_va", int'(voices_active), 0);
    check("rst_l", int'(audio_l), 0);
    check("rst_r", int'(audio_r), 0);

    // Single/dual press vectors aligned to the sample divider
    for (int k = 0; k < 4; k++) begin
      reset_a(vecs[k].lb, vecs[k].pe);
      wait_tick(0);
      #1;
      for (int j = 0; j < 12; j++) push_a(vecs[k].l[j], vecs[k].r[j]);
      pulse_a(vecs[k].btn);
      repeat (5) @(negedge clk);
      check("va_loaded", int'(voices_active), vecs[k].va);
      drain(0);
      check("va_end", int'(voices_active), 0);
    end

    // Voice stealing: third button takes the quieter voice 0
    reset_a(1'b0, 1'b0);
    wait_tick(0);
    #1;
    for (int j = 0; j < 18; j++) push_a(steal_exp[j], steal_exp[j]);
    pulse_a(8'h01);
    repeat (3) wait_tick(0);
    #1 pulse_a(8'h02);
    repeat (3) wait_tick(0);
    #1 pulse_a(8'h04);
    repeat (5) @(negedge clk);
    check("steal_va", int'(voices_active), 3);
    drain(0);
    check("steal_va_end", int'(voices_active), 0);

    // Button held through reset triggers exactly once
    reset = 1'b1; btn = 8'h01;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    check("hold_va_on", int'(voices_active), 1);
    repeat (14) wait_tick(0);
    check("hold_va_off", int'(voices_active), 0);
    #1 btn = '0;

    // Retrigger of the owning voice at amplitude 40
    reset_a(1'b0, 1'b0);
    wait_tick(0);
    #1;
    for (int j = 0; j < 19; j++) push_a(retrig_exp[j], retrig_exp[j]);
    pulse_a(8'h01);
    repeat (7) wait_tick(0);
    #1 pulse_a(8'h01);
    repeat (5) @(negedge clk);
    check("retrig_va", int'(voices_active), 1);
    drain(0);

    // Saturation with four loud voices, then reset mid-play
    #1 reset_b = 1'b0;
    wait_tick(1);
    #1;
    for (int j = 0; j < 9; j++) begin
      samp_t s;
      s.l = sat_exp[j];
      s.r = sat_exp[j];
      q_b.push_back(s);
    end
    btn_b = 8'h0f;
    @(negedge clk);
    #1 btn_b = '0;
    drain(1);
    check("sat_va", int'(voices_active_b), 15);
    #1 reset_b = 1'b1;
    @(negedge clk);
    check("midrst_l", int'(audio_l_b), 0);
    check("midrst_r", int'(audio_r_b), 0);
    check("midrst_va", int'(voices_active_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
